aes_round_sequencer: RTL and testbench

//   Iterative controller for a single shared combinational AES round unit
//   (SubBytes -> ShiftRows -> MixColumns -> AddRoundKey, instantiated outside).

---
 rtl/aes_round_sequencer.sv | 90 +++++++++
 tb/tb_aes_round_sequencer.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/aes_round_sequencer.sv
// Iterative sequencer for a shared combinational AES round unit: accepts one block,
// loops it through the round unit N_ROUNDS times, then offers the result.
module aes_round_sequencer #(
   parameter int N_ROUNDS = 2,
   parameter int RC_IDX_W = 6
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                abort,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [127:0]        in_data,
   input  logic [RC_IDX_W-1:0] in_rc_base,
   output logic [127:0]        rnd_in,
   input  logic [127:0]        rnd_out,
   output logic [RC_IDX_W-1:0] rc_idx,
   output logic                rnd_last,
   output logic                busy,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [127:0]        out_data
);

   localparam int CNT_W = 6;

   typedef enum logic [1:0] {IDLE, RUN, DONE} st_t;

   st_t                 st, st_nx;
   logic [127:0]        state_q, rnd_in_q;
   logic [RC_IDX_W-1:0] rc_base_q, rc_idx_q, rc_cur;
   logic [CNT_W-1:0]    cnt;
   logic                run, accept;

   assign run    = (st == RUN);
   assign accept = (st == IDLE) && in_valid && !abort;
   assign rc_cur = rc_base_q + RC_IDX_W'(cnt);

   // Round-unit drive is live in RUN and frozen at its last value elsewhere.
   assign rnd_in   = run ? state_q : rnd_in_q;
   assign rc_idx   = run ? rc_cur : rc_idx_q;
   assign rnd_last = run && (cnt == CNT_W'(N_ROUNDS - 1));
   assign busy     = (st != IDLE);
   assign out_data = state_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) st <= IDLE;
      else     st <= st_nx;
   end

   always_comb begin
      st_nx     = st;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (st)
         IDLE: begin
            in_ready = !abort;
            if (accept) st_nx = RUN;
         end
         RUN: if (rnd_last) st_nx = DONE;
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) st_nx = IDLE;
         end
         default: st_nx = IDLE;
      endcase
      if (abort) st_nx = IDLE;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= '0;
         rc_base_q <= '0;
         cnt       <= '0;
         rnd_in_q  <= '0;
         rc_idx_q  <= '0;
      end else if (abort) begin
         cnt <= '0;
      end else if (accept) begin
         state_q   <= in_data;
         rc_base_q <= in_rc_base;
         cnt       <= '0;
      end else if (run) begin
         state_q  <= rnd_out;
         cnt      <= cnt + 1'b1;
         rnd_in_q <= state_q;
         rc_idx_q <= rc_cur;
      end
   end

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Bench for aes_round_sequencer with round model rnd_out = rnd_in + rc_idx;
// directed scenarios plus a randomized scoreboard run.
module tb_aes_round_sequencer;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         abort, in_valid, in_ready, rnd_last, busy, out_valid, out_ready;
   logic [127:0] in_data, rnd_in, rnd_out, out_data;
   logic [5:0]   in_rc_base, rc_idx;

   logic         x_in_valid, x_in_ready, x_rnd_last, x_busy, x_out_valid;
   logic [127:0] x_in_data, x_rnd_in, x_rnd_out, x_out_data;
   logic [5:0]   x_in_rc_base, x_rc_idx;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   aes_round_sequencer #(.N_ROUNDS(2), .RC_IDX_W(6)) dut (
      .clk(clk), .rst(rst), .abort(abort), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .in_rc_base(in_rc_base), .rnd_in(rnd_in), .rnd_out(rnd_out),
      .rc_idx(rc_idx), .rnd_last(rnd_last), .busy(busy), .out_valid(out_valid),
      .out_ready(out_ready), .out_data(out_data));

   aes_round_sequencer #(.N_ROUNDS(3), .RC_IDX_W(6)) dut3 (
      .clk(clk), .rst(rst), .abort(1'b0), .in_valid(x_in_valid), .in_ready(x_in_ready),
      .in_data(x_in_data), .in_rc_base(x_in_rc_base), .rnd_in(x_rnd_in), .rnd_out(x_rnd_out),
      .rc_idx(x_rc_idx), .rnd_last(x_rnd_last), .busy(x_busy), .out_valid(x_out_valid),
      .out_ready(1'b1), .out_data(x_out_data));

   // Stand-in round unit
   assign rnd_out   = rnd_in + 128'(rc_idx);
   assign x_rnd_out = x_rnd_in + 128'(x_rc_idx);

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Result = input plus the sum of each round's constant index, indices wrapping mod 64.
   function automatic logic [127:0] model(input logic [127:0] d, input int base, input int n);
      logic [127:0] r = d;
      for (int k = 0; k < n; k++) r = r + 128'((base + k) % 64);
      return r;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   logic [127:0] q[$];
   logic [127:0] d;
   int           got;

   initial begin
      abort = 0; in_valid = 0; in_data = '0; in_rc_base = '0; out_ready = 0;
      x_in_valid = 0; x_in_data = '0; x_in_rc_base = '0;

      // Reset values
      #12;
      chk("rst_out_valid", 128'(out_valid), 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_rnd_in", rnd_in, 0);
      chk("rst_rc_idx", 128'(rc_idx), 0);
      chk("rst_rnd_last", 128'(rnd_last), 0);
      chk("rst_busy", 128'(busy), 0);
      step(); rst = 0; #1;
      chk("rst_in_ready", 128'(in_ready), 1);

      // 1: basic two-round block
      in_valid = 1; in_data = '0; in_rc_base = 6'd5; out_ready = 1;
      step(); in_valid = 0;
      chk("t1_rc0", 128'(rc_idx), 5);
      chk("t1_last0", 128'(rnd_last), 0);
      chk("t1_rdy_run", 128'(in_ready), 0);
      chk("t1_ov0", 128'(out_valid), 0);
      step();
      chk("t1_rc1", 128'(rc_idx), 6);
      chk("t1_last1", 128'(rnd_last), 1);
      chk("t1_rnd_in1", rnd_in, 5);
      step();
      chk("t1_ov", 128'(out_valid), 1);
      chk("t1_data", out_data, 128'h0B);
      chk("t1_last_done", 128'(rnd_last), 0);
      step();
      chk("t1_idle_rdy", 128'(in_ready), 1);
      chk("t1_idle_ov", 128'(out_valid), 0);

      // 2: output backpressure in DONE
      d = {$urandom, $urandom, $urandom, $urandom};
      in_valid = 1; in_data = d; in_rc_base = 6'd2; out_ready = 0;
      step(); in_valid = 0;
      step(); step();
      for (int i = 0; i < 10; i++) begin
         chk("t2_ov_hold", 128'(out_valid), 1);
         chk("t2_data_hold", out_data, model(d, 2, 2));
         chk("t2_rdy_hold", 128'(in_ready), 0);
         step();
      end
      out_ready = 1;
      step();
      chk("t2_rel_rdy", 128'(in_ready), 1);
      chk("t2_rel_busy", 128'(busy), 0);

      // 3: rc index wrap with three rounds
      d = {$urandom, $urandom, $urandom, $urandom};
      x_in_valid = 1; x_in_data = d; x_in_rc_base = 6'd63;
      step(); x_in_valid = 0;
      chk("t3_rc0", 128'(x_rc_idx), 63);
      step();
      chk("t3_rc1", 128'(x_rc_idx), 0);
      step();
      chk("t3_rc2", 128'(x_rc_idx), 1);
      chk("t3_last", 128'(x_rnd_last), 1);
      step();
      chk("t3_ov", 128'(x_out_valid), 1);
      chk("t3_data", x_out_data, d + 128'd64);

      // 4: abort in RUN, then abort beats in_valid in IDLE
      in_valid = 1; in_data = d; in_rc_base = 6'd9;
      step(); in_valid = 0; abort = 1;
      step(); abort = 0;
      chk("t4_busy", 128'(busy), 0);
      for (int i = 0; i < 4; i++) begin
         chk("t4_no_ov", 128'(out_valid), 0);
         step();
      end
      abort = 1; in_valid = 1; #1;
      chk("t4_rdy_abort", 128'(in_ready), 0);
      step(); abort = 0; in_valid = 0;
      chk("t4_no_accept", 128'(busy), 0);

      // 5: reset mid-RUN, then a clean block
      in_valid = 1; in_data = d; in_rc_base = 6'd20;
      step(); in_valid = 0;
      rst = 1; #1;
      chk("t5_busy", 128'(busy), 0);
      chk("t5_rnd_in", rnd_in, 0);
      chk("t5_rc_idx", 128'(rc_idx), 0);
      chk("t5_out_data", out_data, 0);
      chk("t5_ov", 128'(out_valid), 0);
      step(); rst = 0; #1;
      chk("t5_rdy", 128'(in_ready), 1);
      in_valid = 1; in_rc_base = 6'd62;
      step(); in_valid = 0;
      step(); step();
      chk("t5_ov2", 128'(out_valid), 1);
      chk("t5_data2", out_data, model(d, 62, 2));
      step();

      // 6: randomized blocks with stalls on both sides
      got = 0;
      fork
         begin
            for (int i = 0; i < 1000; i++) begin
               int           wd;
               logic         acc;
               logic [127:0] rd;
               int           rb;
               repeat ($urandom_range(0, 2)) step();
               rd = {$urandom, $urandom, $urandom, $urandom};
               rb = $urandom_range(0, 63);
               in_valid = 1; in_data = rd; in_rc_base = 6'(rb);
               wd = 0;
               do begin
                  @(negedge clk);
                  acc = in_ready;
                  step();
                  wd++;
               end while (!acc && wd < 50);
               if (!acc) chk("t6_accept_timeout", 0, 1);
               else q.push_back(model(rd, rb, 2));
               in_valid = 0;
            end
         end
         begin
            int cyc = 0;
            while (got < 1000 && cyc < 40000) begin
               @(negedge clk);
               out_ready = 1'($urandom_range(0, 1));
               #1;
               if (out_valid && out_ready) begin
                  if (q.size() == 0) chk("t6_dup", 128'(out_valid), 0);
                  else chk("t6_data", out_data, q.pop_front());
                  got++;
               end
               cyc++;
            end
            if (got < 1000) chk("t6_timeout", 128'(got), 1000);
         end
      join
      chk("t6_left", 128'(q.size()), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
